// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: recode operations
// produced by m_to_y and the controller state encoding.
package booth_pkg;

   localparam logic [1:0] ZERO  = 2'b00;
   localparam logic [1:0] PLUS  = 2'b01;
   localparam logic [1:0] MINUS = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/m_to_y.sv
// Radix-2 Booth recoder: maps the multiplier bit pair {q0, q_m1} to the
// add/subtract/none operation for the current step.
module m_to_y
   import booth_pkg::*;
(
   input  logic       q0,
   input  logic       q_m1,
   output logic [1:0] y
);

   always_comb begin
      y = ZERO;
      case ({q0, q_m1})
         2'b01:   y = PLUS;
         2'b10:   y = MINUS;
         default: y = ZERO;
      endcase
   end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed radix-2 Booth multiplier: one add/subtract/shift step per
// clock, start/done handshake, 2*WIDTH-bit two's-complement product.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   m_reg;
   logic [WIDTH-1:0]   q_reg;
   logic [WIDTH:0]     a_reg;
   logic               q_m1;
   logic [CNT_W-1:0]   cnt;

   logic [1:0]         op;
   logic [WIDTH:0]     m_ext;
   logic [WIDTH:0]     a_sum;
   logic [WIDTH:0]     a_shift;
   logic [WIDTH-1:0]   q_shift;
   logic               last;

   m_to_y u_recode (
      .q0   (q_reg[0]),
      .q_m1 (q_m1),
      .y    (op)
   );

   // A carries one guard bit so M = -2^(WIDTH-1) never overflows the accumulator.
   assign m_ext = {m_reg[WIDTH-1], m_reg};
   assign last  = (cnt == CNT_W'(1));

   always_comb begin
      a_sum = a_reg;
      case (op)
         PLUS:    a_sum = a_reg + m_ext;
         MINUS:   a_sum = a_reg - m_ext;
         default: a_sum = a_reg;
      endcase
   end

   assign a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
   assign q_shift = {a_sum[0], q_reg[WIDTH-1:1]};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state_nxt == DONE);
      end
   end

   // Product is captured from the final shift on the RUN->DONE edge so it is
   // already valid in the cycle where done is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_reg   <= '0;
         q_reg   <= '0;
         a_reg   <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m_reg <= multiplicand;
                  q_reg <= multiplier;
                  a_reg <= '0;
                  q_m1  <= 1'b0;
                  cnt   <= CNT_W'(WIDTH);
               end
            end
            RUN: begin
               a_reg <= a_shift;
               q_reg <= q_shift;
               q_m1  <= q_reg[0];
               cnt   <= cnt - CNT_W'(1);
               if (last)
                  product <= {a_shift[WIDTH-1:0], q_shift};
            end
            default: ;
         endcase
      end
   end

   recode_legal: assert property (@(posedge clk) disable iff (reset)
      (state == RUN) |-> (op != 2'b11));

endmodule
